// File: rtl/cnt4_2x_pkg.sv
// Shared constants and standard-cell gate models for the cnt4_2x counter.
package cnt4_2x_pkg;

  localparam int          CNT_W   = 4;
  localparam logic [3:0]  CNT_RST = 4'b0000;
  localparam logic [3:0]  CNT_MAX = 4'b1111;

  // 2-input NAND cell.
  function automatic logic nand_2x(input logic a, input logic b);
    return ~(a & b);
  endfunction

  // 2-input NOR cell.
  function automatic logic nor_2x(input logic a, input logic b);
    return ~(a | b);
  endfunction

  // Inverter cell.
  function automatic logic inv(input logic a);
    return ~a;
  endfunction

  // 4-input AND from the downstream gate stage, reused for the terminal-count decode.
  function automatic logic and4_2x(input logic [3:0] a);
    return a[0] & a[1] & a[2] & a[3];
  endfunction

  // Exclusive-OR assembled from four NAND cells, used for the toggle of each counter bit.
  function automatic logic xor_nand(input logic a, input logic b);
    logic n1;
    n1 = nand_2x(a, b);
    return nand_2x(nand_2x(a, n1), nand_2x(b, n1));
  endfunction

endpackage

// File: rtl/dff_rstb_2x.sv
// Single D flop with asynchronous active-low reset; one per stored counter bit.
module dff_rstb_2x #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // Capture d on the rising edge; reset forces the flop immediately, independent of the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/cnt4_2x.sv
// 4-bit loadable up-counter with terminal count, chainable carry-out and sticky overflow.
// Next-state logic is expressed purely in NAND/NOR/INV cells so it maps one-to-one onto the row.
module cnt4_2x
  import cnt4_2x_pkg::*;
(
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             EN,
  input  logic             LD,
  input  logic [CNT_W-1:0] DIN,
  output logic [CNT_W-1:0] Q,
  output logic             TC,
  output logic             CO,
  output logic             OVF
);

  logic [CNT_W-1:0] q_q;
  logic [CNT_W-1:0] q_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [CNT_W:0]   carry;
  logic [CNT_W-1:0] toggle;
  logic             ld_n;

  // Carry chain, per-bit toggle and load/increment/hold mux; carry[CNT_W] marks the wrap edge.
  always_comb begin
    carry  = '0;
    toggle = '0;
    q_d    = '0;
    ld_n   = inv(LD);
    carry[0] = EN;
    for (int i = 0; i < CNT_W; i++) begin
      toggle[i]  = xor_nand(q_q[i], carry[i]);
      carry[i+1] = inv(nand_2x(carry[i], q_q[i]));
      q_d[i]     = nand_2x(nand_2x(LD, DIN[i]), nand_2x(ld_n, toggle[i]));
    end
    ovf_d = nor_2x(LD, nor_2x(ovf_q, carry[CNT_W]));
  end

  // Counter state flops, one cell per bit.
  for (genvar g = 0; g < CNT_W; g++) begin : g_q_ff
    dff_rstb_2x #(.RST_VAL(CNT_RST[g])) u_q_ff (
      .clk   (CLK),
      .rst_n (RSTB),
      .d     (q_d[g]),
      .q     (q_q[g])
    );
  end

  // Sticky overflow flop: set by a wrap, cleared only by load or reset.
  dff_rstb_2x #(.RST_VAL(1'b0)) u_ovf_ff (
    .clk   (CLK),
    .rst_n (RSTB),
    .d     (ovf_d),
    .q     (ovf_q)
  );

  assign Q   = q_q;
  assign OVF = ovf_q;
  assign TC  = and4_2x(q_q);
  assign CO  = nor_2x(nand_2x(TC, EN), LD);

endmodule

// File: tb/tb_cnt4_2x.sv
// Scoreboard bench for cnt4_2x: a single counter for directed cases plus a chained pair.
module tb_cnt4_2x;

  typedef struct {
    string      name;
    bit         chain;
    logic [7:0] q;
    logic [1:0] tc;
    logic [1:0] co;
    logic [1:0] ovf;
  } exp_t;

  logic       clk;
  logic       rstb;
  logic       en;
  logic       ld;
  logic [3:0] din;
  logic [3:0] q;
  logic       tc;
  logic       co;
  logic       ovf;

  logic       crstb;
  logic       cen;
  logic       cld;
  logic [3:0] cdin;
  logic [3:0] q_lo;
  logic [3:0] q_hi;
  logic       tc_lo;
  logic       tc_hi;
  logic       co_lo;
  logic       co_hi;
  logic       ovf_lo;
  logic       ovf_hi;

  logic [3:0] mq;
  logic       movf;

  int checks   = 0;
  int failures = 0;

  exp_t sb[$];
  event check_ev;

  cnt4_2x dut (
    .CLK  (clk),
    .RSTB (rstb),
    .EN   (en),
    .LD   (ld),
    .DIN  (din),
    .Q    (q),
    .TC   (tc),
    .CO   (co),
    .OVF  (ovf)
  );

  cnt4_2x u_lo (
    .CLK  (clk),
    .RSTB (crstb),
    .EN   (cen),
    .LD   (cld),
    .DIN  (cdin),
    .Q    (q_lo),
    .TC   (tc_lo),
    .CO   (co_lo),
    .OVF  (ovf_lo)
  );

  cnt4_2x u_hi (
    .CLK  (clk),
    .RSTB (crstb),
    .EN   (co_lo),
    .LD   (1'b0),
    .DIN  (4'b0000),
    .Q    (q_hi),
    .TC   (tc_hi),
    .CO   (co_hi),
    .OVF  (ovf_hi)
  );

  // Free-running 10-unit clock shared by both counters.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one scoreboard entry against the counter it refers to.
  task automatic checkOutput(input exp_t e);
    logic [7:0] aq;
    logic [1:0] atc;
    logic [1:0] aco;
    logic [1:0] aovf;
    if (e.chain) begin
      aq   = {q_hi, q_lo};
      atc  = {tc_hi, tc_lo};
      aco  = {co_hi, co_lo};
      aovf = {ovf_hi, ovf_lo};
    end else begin
      aq   = {4'h0, q};
      atc  = {1'b0, tc};
      aco  = {1'b0, co};
      aovf = {1'b0, ovf};
    end
    checks++;
    if (aq !== e.q || atc !== e.tc || aco !== e.co || aovf !== e.ovf) begin
      failures++;
      $display("[TB] FAIL %s: got q=%h tc=%b co=%b ovf=%b, expected q=%h tc=%b co=%b ovf=%b",
               e.name, aq, atc, aco, aovf, e.q, e.tc, e.co, e.ovf);
    end
  endtask

  // Monitor: whenever the stimulus side marks outputs as settled, drain the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(check_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  // Advance one rising edge and let the outputs settle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Queue an expectation for the single counter and hand it to the monitor.
  task automatic expectSingle(input string name, input logic [3:0] eq, input logic etc,
                              input logic eco, input logic eovf);
    sb.push_back('{name, 1'b0, {4'h0, eq}, {1'b0, etc}, {1'b0, eco}, {1'b0, eovf}});
    -> check_ev;
    #1;
  endtask

  // Queue an expectation for the chained pair.
  task automatic expectChain(input string name, input logic [7:0] eq, input logic [1:0] etc,
                             input logic [1:0] eco, input logic [1:0] eovf);
    sb.push_back('{name, 1'b1, eq, etc, eco, eovf});
    -> check_ev;
    #1;
  endtask

  // Count n edges with EN high, tracking the expected value and overflow alongside.
  task automatic runCount(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      en = 1'b1;
      ld = 1'b0;
      applyStimulus();
      if (mq == 4'hF) movf = 1'b1;
      mq = mq + 4'd1;
      expectSingle(name, mq, mq == 4'hF, mq == 4'hF, movf);
    end
  endtask

  // Directed sequence followed by the chained 8-bit count.
  initial begin
    logic [7:0] n8;
    rstb = 1'b0; en = 1'b1; ld = 1'b0; din = 4'h0;
    crstb = 1'b0; cen = 1'b0; cld = 1'b0; cdin = 4'h0;
    mq = 4'h0; movf = 1'b0;

    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      expectSingle("reset_hold", 4'b0000, 1'b0, 1'b0, 1'b0);
    end
    rstb = 1'b1;
    runCount(5, "count_up");
    expectSingle("count5", 4'b0101, 1'b0, 1'b0, 1'b0);

    rstb = 1'b0;
    #1;
    mq = 4'h0; movf = 1'b0;
    expectSingle("async_zero", 4'b0000, 1'b0, 1'b0, 1'b0);
    rstb = 1'b1;

    runCount(15, "count_to_max");
    expectSingle("at_max", 4'b1111, 1'b1, 1'b1, 1'b0);
    runCount(1, "wrap");
    expectSingle("wrapped", 4'b0000, 1'b0, 1'b0, 1'b1);
    runCount(16, "second_lap");
    expectSingle("ovf_sticky", 4'b0000, 1'b0, 1'b0, 1'b1);
    runCount(3, "to_three");
    expectSingle("at_three", 4'b0011, 1'b0, 1'b0, 1'b1);

    ld = 1'b1; en = 1'b1; din = 4'b1010;
    applyStimulus();
    mq = 4'b1010; movf = 1'b0;
    expectSingle("load_over_en", 4'b1010, 1'b0, 1'b0, 1'b0);
    ld = 1'b1; en = 1'b0; din = 4'b1111;
    applyStimulus();
    mq = 4'b1111;
    expectSingle("load_max", 4'b1111, 1'b1, 1'b0, 1'b0);
    ld = 1'b0; en = 1'b0;
    #1;
    expectSingle("max_idle", 4'b1111, 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    #1;
    expectSingle("max_en_co", 4'b1111, 1'b1, 1'b1, 1'b0);
    ld = 1'b1; din = 4'b0110;
    #1;
    expectSingle("wrap_ld_co", 4'b1111, 1'b1, 1'b0, 1'b0);
    applyStimulus();
    mq = 4'b0110;
    expectSingle("load_during_wrap", 4'b0110, 1'b0, 1'b0, 1'b0);

    runCount(10, "lap_from_six");
    runCount(9, "to_nine");
    expectSingle("pre_reset", 4'b1001, 1'b0, 1'b0, 1'b1);
    rstb = 1'b0;
    #1;
    mq = 4'h0; movf = 1'b0;
    expectSingle("async_mid", 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      expectSingle("reset_clk", 4'b0000, 1'b0, 1'b0, 1'b0);
    end
    rstb = 1'b1;

    expectChain("chain_reset", 8'h00, 2'b00, 2'b00, 2'b00);
    crstb = 1'b1;
    cen   = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      applyStimulus();
      n8 = n[7:0];
      expectChain((n == 255) ? "chain_max" : (n == 256) ? "chain_wrap" : "chain_count",
                  n8,
                  {n8[7:4] == 4'hF, n8[3:0] == 4'hF},
                  {(n8[7:4] == 4'hF) && (n8[3:0] == 4'hF), n8[3:0] == 4'hF},
                  {n >= 256, n >= 16});
    end

    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
